// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - two-stage pipelined carry-lookahead add/subtract unit with C/V/Z/N flags
module cla_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag,
    output logic             n_flag,
    output logic             cf
);
    localparam int L = WIDTH / 2;

    // Carries inside a group are sum-of-products of the group's g/p terms; groups chain on c[base].
    function automatic logic [L:0] cla_half(input logic [L-1:0] x, input logic [L-1:0] y,
                                            input logic ci);
        logic [L-1:0] p;
        logic [L-1:0] g;
        logic [L-1:0] s;
        logic [L:0]   c;
        logic         acc;
        logic         pp;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int base = 0; base < L; base += GRP) begin
            for (int j = 1; j <= GRP; j++) begin
                pp = 1'b1;
                for (int m = 0; m < j; m++) pp = pp & p[base+m];
                acc = c[base] & pp;
                for (int k = 0; k < j; k++) begin
                    pp = 1'b1;
                    for (int m = k + 1; m < j; m++) pp = pp & p[base+m];
                    acc = acc | (g[base+k] & pp);
                end
                c[base+j] = acc;
            end
        end
        s = p ^ c[L-1:0];
        return {c[L], s};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [L-1:0]     lo_sum_q, lo_sum_d;
    logic             lo_cout_q, lo_cout_d;
    logic [L-1:0]     a_hi_q, a_hi_d;
    logic [L-1:0]     b_hi_q, b_hi_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic             cf_q, cf_d;

    logic             s2_free, s1_adv, s1_free, accept, cin;
    logic [WIDTH-1:0] b_eff;
    logic [L:0]       lo_res, hi_res;

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        s1_free  = !s1_valid_q || s1_adv;
        // ADC/SBC must wait for S1 to empty so cf already reflects every older op.
        in_ready = s1_free && !(op[1] && s1_valid_q);
        accept   = in_valid && in_ready;
        b_eff    = op[0] ? ~b : b;
        cin      = op[1] ? cf_q : op[0];
        lo_res   = cla_half(a[L-1:0], b_eff[L-1:0], cin);
        hi_res   = cla_half(a_hi_q, b_hi_q, lo_cout_q);

        s1_valid_d  = s1_valid_q;
        lo_sum_d    = lo_sum_q;
        lo_cout_d   = lo_cout_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        cf_d        = cf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            lo_sum_d   = lo_res[L-1:0];
            lo_cout_d  = lo_res[L];
            a_hi_d     = a[WIDTH-1:L];
            b_hi_d     = b_eff[WIDTH-1:L];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            sum_d       = {hi_res[L-1:0], lo_sum_q};
            c_d         = hi_res[L];
            v_d         = (a_hi_q[L-1] == b_hi_q[L-1]) && (hi_res[L-1] != a_hi_q[L-1]);
            z_d         = ~|sum_d;
            n_d         = hi_res[L-1];
            cf_d        = hi_res[L];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            lo_sum_q    <= '0;
            lo_cout_q   <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            cf_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_sum_q    <= lo_sum_d;
            lo_cout_q   <= lo_cout_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
            cf_q        <= cf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_flag    = c_q;
    assign v_flag    = v_q;
    assign z_flag    = z_q;
    assign n_flag    = n_q;
    assign cf        = cf_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - self-checking bench for cla_addsub_pipe (8-bit and 16-bit instances)
module tb_cla_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_ready;

    logic        in_ready8, out_valid8, c8, v8, z8, n8, cf8;
    logic [7:0]  sum8;
    logic        in_ready16, out_valid16, c16, v16, z16, n16, cf16;
    logic [15:0] sum16;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(8), .GRP(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .c_flag(c8), .v_flag(v8), .z_flag(z8), .n_flag(n8), .cf(cf8)
    );

    cla_addsub_pipe #(.WIDTH(16), .GRP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .op(op),
        .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
        .c_flag(c16), .v_flag(v16), .z_flag(z16), .n_flag(n16), .cf(cf16)
    );

    typedef struct {
        logic [15:0] sum;
        logic        c, v, z, n;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b, sum;
        logic       c, v, z, n, cf;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q8[$];
    res_t q16[$];
    logic mcf8, mcf16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result = (a + b' + cin) mod 2^w, with b' and cin chosen by op.
    function automatic res_t ref_op(input int w, input logic [1:0] o, input logic [15:0] x,
                                    input logic [15:0] y, input logic cfin);
        res_t        r;
        int unsigned mask, xa, yb, full, am, bm, sm;
        mask  = (32'd1 << w) - 1;
        xa    = 32'(x) & mask;
        yb    = o[0] ? (~32'(y) & mask) : (32'(y) & mask);
        full  = xa + yb + ((o[1] ? cfin : o[0]) ? 32'd1 : 32'd0);
        r.sum = 16'(full & mask);
        r.c   = ((full >> w) & 1) != 0;
        am    = (xa >> (w - 1)) & 1;
        bm    = (yb >> (w - 1)) & 1;
        sm    = ((full & mask) >> (w - 1)) & 1;
        r.v   = (am == bm) && (sm != am);
        r.z   = (full & mask) == 0;
        r.n   = sm != 0;
        return r;
    endfunction

    task automatic rand_cycle(input bit drain);
        res_t r;
        logic acc8, acc16, ret8, ret16;
        @(negedge clk);
        if (out_valid8) begin
            if (q8.size() == 0) chk("r8_spurious", 32'(out_valid8), 32'd0);
            else chk("r8_result", {12'h0, sum8, c8, v8, z8, n8},
                     {12'h0, q8[0].sum[7:0], q8[0].c, q8[0].v, q8[0].z, q8[0].n});
        end
        if (out_valid16) begin
            if (q16.size() == 0) chk("r16_spurious", 32'(out_valid16), 32'd0);
            else chk("r16_result", {12'h0, sum16, c16, v16, z16, n16},
                     {12'h0, q16[0].sum, q16[0].c, q16[0].v, q16[0].z, q16[0].n});
        end
        if (q8.size() == 0) chk("r8_cf", 32'(cf8), 32'(mcf8));
        if (q16.size() == 0) chk("r16_cf", 32'(cf16), 32'(mcf16));
        in_valid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
        op        = 2'($urandom_range(0, 3));
        a         = 16'($urandom);
        b         = 16'($urandom);
        out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        acc8  = in_valid && in_ready8;
        acc16 = in_valid && in_ready16;
        ret8  = out_valid8 && out_ready;
        ret16 = out_valid16 && out_ready;
        if (ret8 && q8.size() > 0) void'(q8.pop_front());
        if (ret16 && q16.size() > 0) void'(q16.pop_front());
        if (acc8) begin
            r = ref_op(8, op, a, b, mcf8);
            q8.push_back(r);
            mcf8 = r.c;
        end
        if (acc16) begin
            r = ref_op(16, op, a, b, mcf16);
            q16.push_back(r);
            mcf16 = r.c;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t        tbl[12];
    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    logic [7:0]  bp_exp[4];
    int          idx, got, cyc;

    initial begin
        tbl[0]  = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 8'h10, 8'h20, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 8'h20, 8'h10, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{2'b11, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bp_a    = '{16'h10, 16'h20, 16'h30, 16'h40};
        bp_b    = '{16'h01, 16'h02, 16'h03, 16'h04};
        bp_exp  = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid8), 32'd0);
        chk("reset_sum_flags", {sum8, c8, v8, z8, n8, cf8}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = tbl[i].op; a = {8'h0, tbl[i].a}; b = {8'h0, tbl[i].b};
            out_ready = 1'b1;
            #1 chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready8), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_early", i), 32'(out_valid8), 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid8), 32'd1);
            chk($sformatf("tbl%0d_result", i), {sum8, c8, v8, z8, n8, cf8},
                {tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n, tbl[i].cf});
        end

        // Two-word chain: ADC must stall one cycle behind the ADD.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 16'h00FF; b = 16'h0001;
        #1 chk("chain_add_ready", 32'(in_ready8), 32'd1);
        @(negedge clk);
        op = 2'b10; a = 16'h0012; b = 16'h0034;
        #1 chk("chain_adc_stall", 32'(in_ready8), 32'd0);
        @(negedge clk);
        #1 chk("chain_adc_ready", 32'(in_ready8), 32'd1);
        chk("chain_lo", {out_valid8, sum8, c8, cf8}, {1'b1, 8'h00, 1'b1, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("chain_hi", {out_valid8, sum8, c8, cf8}, {1'b1, 8'h47, 1'b0, 1'b0});

        // Backpressure: out_ready low for three cycles while four ADDs stream in.
        @(negedge clk);
        idx = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 30) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            op        = 2'b00;
            a         = bp_a[idx < 4 ? idx : 3];
            b         = bp_b[idx < 4 ? idx : 3];
            #1;
            if (cyc < 2) chk($sformatf("bp_ready_c%0d", cyc), 32'(in_ready8), 32'd1);
            if (cyc == 2) begin
                chk("bp_stall", 32'(in_ready8), 32'd0);
                chk("bp_hold_valid", 32'(out_valid8), 32'd1);
            end
            if (out_valid8) begin
                chk($sformatf("bp_order%0d", got), 32'(sum8), 32'(bp_exp[got]));
                if (out_ready) got++;
            end
            if (in_valid && in_ready8) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_retired", 32'(got), 32'd4);
        in_valid = 1'b0;

        // Asynchronous reset with beats in flight and cf set.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 16'h00FF; b = 16'h0001; out_ready = 1'b0;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        #2 chk("pre_rst_cf", {out_valid8, cf8}, {1'b1, 1'b1});
        rst_n = 1'b0;
        #1 chk("mid_rst", {out_valid8, sum8, c8, v8, z8, n8, cf8}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", i), 32'(out_valid8), 32'd0);
        end

        do_reset();
        mcf8 = 1'b0; mcf16 = 1'b0;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 10; i++) rand_cycle(1'b1);
        chk("r8_drained", 32'(q8.size()), 32'd0);
        chk("r16_drained", 32'(q16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
